// File: rtl/lsu_mem_port.sv
// Load/store unit bridging the execute stage to a handshaked data memory.
// One access in flight; decode faults and bus timeouts come back as cause codes.
module lsu_mem_port #(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic                i_req_wen,
  input  logic [2:0]          i_req_funct3,
  input  logic [XLEN-1:0]     i_req_addr,
  input  logic [XLEN-1:0]     i_req_wdata,
  output logic                o_rsp_valid,
  output logic [XLEN-1:0]     o_rsp_rdata,
  output logic [1:0]          o_rsp_cause,
  output logic [XLEN-1:0]     o_mem_addr,
  output logic                o_mem_ren,
  output logic                o_mem_wen,
  output logic [XLEN-1:0]     o_mem_wdata,
  output logic [XLEN/8-1:0]   o_mem_mask,
  input  logic                i_mem_ready,
  input  logic                i_mem_valid,
  input  logic [XLEN-1:0]     i_mem_rdata
);

  localparam int NB = XLEN / 8;
  localparam int OB = $clog2(NB);
  localparam int CW = $clog2(MAX_WAIT + 2);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [1:0] C_OK    = 2'd0;
  localparam logic [1:0] C_MISAL = 2'd1;
  localparam logic [1:0] C_ILL   = 2'd2;
  localparam logic [1:0] C_TMO   = 2'd3;

  function automatic logic [NB-1:0] f_mask(input logic [1:0] sz, input logic [OB-1:0] off);
    logic [NB-1:0] m;
    // 1 << NB wraps to zero, so the subtraction still yields all lanes for full width
    m = (NB'(1) << (4'd1 << sz)) - NB'(1);
    return m << off;
  endfunction

  function automatic logic [XLEN-1:0] f_wdata(input logic [XLEN-1:0] d, input logic [1:0] sz);
    logic [XLEN-1:0] r;
    case (sz)
      2'd0:    r = {NB{d[7:0]}};
      2'd1:    r = {(NB/2){d[15:0]}};
      2'd2:    r = {(NB/4){d[31:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [XLEN-1:0] f_load_ext(input logic [XLEN-1:0] word,
                                                  input logic [OB-1:0]   off,
                                                  input logic [2:0]      f3);
    logic [XLEN-1:0] s;
    logic [6:0]      sh;
    s  = word >> {off, 3'b000};
    sh = 7'(XLEN) - (7'd8 << f3[1:0]);
    // left-justify the field, then shift back down arithmetically or logically
    s  = s << sh;
    if (f3[2]) s = s >> sh;
    else       s = $unsigned($signed(s) >>> sh);
    return s;
  endfunction

  logic [1:0]      r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_rsp_valid;
  logic [XLEN-1:0] r_rsp_rdata;
  logic [1:0]      r_rsp_cause;
  logic            r_wen;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;

  logic            w_accept;
  logic            w_issue;
  logic            w_ill;
  logic            w_mis;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_tmo;

  assign o_req_ready = (r_state == S_IDLE) & ~i_rst;
  assign w_accept    = i_req_valid & o_req_ready;
  assign w_issue     = (r_state == S_ISSUE);

  assign w_ill = (i_req_funct3 == 3'b111)
               | ((XLEN == 32) & ((i_req_funct3 == 3'b011) | (i_req_funct3 == 3'b110)))
               | (i_req_wen & i_req_funct3[2]);

  always_comb begin
    w_mis = 1'b0;
    case (i_req_funct3[1:0])
      2'd1:    w_mis = i_req_addr[0];
      2'd2:    w_mis = |i_req_addr[1:0];
      2'd3:    w_mis = |i_req_addr[2:0];
      default: w_mis = 1'b0;
    endcase
  end

  assign w_cnt_nxt = r_cnt + CW'(1);
  assign w_tmo     = (MAX_WAIT != 0) && (w_cnt_nxt == CW'(MAX_WAIT));

  assign o_mem_ren   = w_issue & ~r_wen;
  assign o_mem_wen   = w_issue & r_wen;
  assign o_mem_addr  = w_issue ? {r_addr[XLEN-1:OB], {OB{1'b0}}} : '0;
  assign o_mem_mask  = w_issue ? f_mask(r_funct3[1:0], r_addr[OB-1:0]) : '0;
  assign o_mem_wdata = w_issue ? f_wdata(r_wdata, r_funct3[1:0]) : '0;

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_cause = r_rsp_cause;

  // Request capture: data only, qualified by the accept handshake
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_wen    <= i_req_wen;
      r_funct3 <= i_req_funct3;
      r_addr   <= i_req_addr;
      r_wdata  <= i_req_wdata;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_cause <= C_OK;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_ill) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= '0;
              r_rsp_cause <= C_ILL;
            end else if (w_mis) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= '0;
              r_rsp_cause <= C_MISAL;
            end else begin
              r_state <= S_ISSUE;
              r_cnt   <= '0;
            end
          end
        end
        S_ISSUE: begin
          r_cnt <= w_cnt_nxt;
          if (w_tmo) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= '0;
            r_rsp_cause <= C_TMO;
          end else if (i_mem_ready) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= w_cnt_nxt;
          // completion on the limit cycle beats the timeout
          if (i_mem_valid) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= r_wen ? '0 : f_load_ext(i_mem_rdata, r_addr[OB-1:0], r_funct3);
            r_rsp_cause <= C_OK;
          end else if (w_tmo) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= '0;
            r_rsp_cause <= C_TMO;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Scoreboard bench for lsu_mem_port: three instances (32-bit, 64-bit, 32-bit short timeout).
module tb_lsu_mem_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_wen;
  logic [2:0]  req_f3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        mready;
  logic        mvalid;
  logic [63:0] mrdata;
  int          sel;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rdy_a, rv_a, ren_a, wen_a;
  logic [31:0] rd_a, ma_a, wd_a;
  logic [1:0]  rc_a;
  logic [3:0]  mk_a;
  logic        rdy_b, rv_b, ren_b, wen_b;
  logic [63:0] rd_b, ma_b, wd_b;
  logic [1:0]  rc_b;
  logic [7:0]  mk_b;
  logic        rdy_c, rv_c, ren_c, wen_c;
  logic [31:0] rd_c, ma_c, wd_c;
  logic [1:0]  rc_c;
  logic [3:0]  mk_c;

  lsu_mem_port #(.XLEN(32), .MAX_WAIT(16)) u_a (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid && sel == 0), .o_req_ready(rdy_a),
    .i_req_wen(req_wen), .i_req_funct3(req_f3), .i_req_addr(req_addr[31:0]),
    .i_req_wdata(req_wdata[31:0]), .o_rsp_valid(rv_a), .o_rsp_rdata(rd_a), .o_rsp_cause(rc_a),
    .o_mem_addr(ma_a), .o_mem_ren(ren_a), .o_mem_wen(wen_a), .o_mem_wdata(wd_a),
    .o_mem_mask(mk_a), .i_mem_ready(mready), .i_mem_valid(mvalid), .i_mem_rdata(mrdata[31:0]));

  lsu_mem_port #(.XLEN(64), .MAX_WAIT(16)) u_b (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid && sel == 1), .o_req_ready(rdy_b),
    .i_req_wen(req_wen), .i_req_funct3(req_f3), .i_req_addr(req_addr),
    .i_req_wdata(req_wdata), .o_rsp_valid(rv_b), .o_rsp_rdata(rd_b), .o_rsp_cause(rc_b),
    .o_mem_addr(ma_b), .o_mem_ren(ren_b), .o_mem_wen(wen_b), .o_mem_wdata(wd_b),
    .o_mem_mask(mk_b), .i_mem_ready(mready), .i_mem_valid(mvalid), .i_mem_rdata(mrdata));

  lsu_mem_port #(.XLEN(32), .MAX_WAIT(4)) u_c (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid && sel == 2), .o_req_ready(rdy_c),
    .i_req_wen(req_wen), .i_req_funct3(req_f3), .i_req_addr(req_addr[31:0]),
    .i_req_wdata(req_wdata[31:0]), .o_rsp_valid(rv_c), .o_rsp_rdata(rd_c), .o_rsp_cause(rc_c),
    .o_mem_addr(ma_c), .o_mem_ren(ren_c), .o_mem_wen(wen_c), .o_mem_wdata(wd_c),
    .o_mem_mask(mk_c), .i_mem_ready(mready), .i_mem_valid(mvalid), .i_mem_rdata(mrdata[31:0]));

  logic [63:0] rdy, rv, rd, rc, maddr, ren, wen, mwd, mask;

  always_comb begin
    rdy = '0; rv = '0; rd = '0; rc = '0; maddr = '0; ren = '0; wen = '0; mwd = '0; mask = '0;
    case (sel)
      0: begin
        rdy = 64'(rdy_a); rv = 64'(rv_a); rd = 64'(rd_a); rc = 64'(rc_a); maddr = 64'(ma_a);
        ren = 64'(ren_a); wen = 64'(wen_a); mwd = 64'(wd_a); mask = 64'(mk_a);
      end
      1: begin
        rdy = 64'(rdy_b); rv = 64'(rv_b); rd = rd_b; rc = 64'(rc_b); maddr = ma_b;
        ren = 64'(ren_b); wen = 64'(wen_b); mwd = wd_b; mask = 64'(mk_b);
      end
      default: begin
        rdy = 64'(rdy_c); rv = 64'(rv_c); rd = 64'(rd_c); rc = 64'(rc_c); maddr = 64'(ma_c);
        ren = 64'(ren_c); wen = 64'(wen_c); mwd = 64'(wd_c); mask = 64'(mk_c);
      end
    endcase
  end

  typedef struct {
    logic [63:0] rdata;
    logic [63:0] cause;
    logic [63:0] cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (ren[0] && wen[0]) chk("ren_wen_excl", 64'd1, 64'd0);
      if (rv[0]) begin
        if (sb.size() == 0) begin
          chk("spurious_rsp", 64'd1, 64'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("rsp_rdata", rd, mon_e.rdata);
          chk("rsp_cause", rc, mon_e.cause);
          chk("rsp_cycle", 64'(cyc), mon_e.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request on instance k; returns in the cycle after the accept edge.
  task automatic send(input int k, input logic w, input logic [2:0] f3,
                      input logic [63:0] a, input logic [63:0] d);
    sel = k; req_wen = w; req_f3 = f3; req_addr = a; req_wdata = d;
    #1;
    chk("req_ready", rdy, 64'd1);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  // Response expected in cycle accept+lat.
  task automatic expect_rsp(input logic [63:0] r, input logic [63:0] c, input int lat);
    sb.push_back('{r, c, 64'(cyc + lat - 1)});
  endtask

  task automatic access0(input int k, input logic w, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] d, input logic [63:0] word, input logic [63:0] exp_rd,
                         input logic [63:0] exp_addr, input logic [63:0] exp_mask,
                         input logic [63:0] exp_wd);
    send(k, w, f3, a, d);
    expect_rsp(exp_rd, 64'd0, 3);
    chk("acc_addr", maddr, exp_addr);
    chk("acc_mask", mask, exp_mask);
    chk("acc_wdata", mwd, exp_wd);
    chk("acc_dir", {wen[0], ren[0]}, w ? 64'd2 : 64'd1);
    mready = 1'b1; tick(); mready = 1'b0;
    mvalid = 1'b1; mrdata = word; tick(); mvalid = 1'b0;
    tick();
  endtask

  task automatic fault(input logic w, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] c);
    send(0, w, f3, a, 64'h5555_5555);
    expect_rsp(64'd0, c, 1);
    chk("flt_ren", ren, 64'd0);
    chk("flt_wen", wen, 64'd0);
    tick();
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_f3 = 3'd0; req_addr = '0; req_wdata = '0;
    mready = 1'b0; mvalid = 1'b0; mrdata = '0; sel = 0;
    #12;
    chk("rst_ready", rdy, 64'd0);
    chk("rst_rsp_valid", rv, 64'd0);
    chk("rst_rsp_rdata", rd, 64'd0);
    chk("rst_mem", maddr | ren | wen | mwd | mask, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("ready_after_rst", rdy, 64'd1);

    // lb at 0x1003, two wait cycles before data
    send(0, 1'b0, 3'b000, 64'h1003, 64'h0);
    expect_rsp(64'hFFFF_FF80, 64'd0, 5);
    chk("t1_addr", maddr, 64'h1000);
    chk("t1_mask", mask, 64'h8);
    chk("t1_ren", ren, 64'd1);
    mready = 1'b1; tick(); mready = 1'b0;
    chk("t1_wait_ren", ren, 64'd0);
    chk("t1_wait_addr", maddr, 64'd0);
    tick(); tick();
    mvalid = 1'b1; mrdata = 64'h80FF_FF12; tick(); mvalid = 1'b0;
    chk("t1_resp_ready", rdy, 64'd0);
    tick();

    // sh with memory stalling three cycles
    send(0, 1'b1, 3'b001, 64'h2002, 64'h0000_ABCD);
    expect_rsp(64'd0, 64'd0, 6);
    for (int i = 0; i < 4; i++) begin
      chk("t2_addr", maddr, 64'h2000);
      chk("t2_mask", mask, 64'hC);
      chk("t2_wdata", mwd, 64'hABCD_ABCD);
      chk("t2_dir", {wen[0], ren[0]}, 64'd2);
      if (i == 3) mready = 1'b1;
      tick();
    end
    mready = 1'b0; mvalid = 1'b1; mrdata = 64'hFFFF_FFFF; tick(); mvalid = 1'b0;
    tick();

    access0(0, 1'b1, 3'b010, 64'h1004, 64'hCAFE_F00D, 64'hFFFF_FFFF, 64'd0,
            64'h1004, 64'hF, 64'hCAFE_F00D);

    // Fault decode; the last one leaves cause 2 held on the response port
    fault(1'b0, 3'b010, 64'h1001, 64'd1);
    fault(1'b0, 3'b001, 64'h1001, 64'd1);
    fault(1'b1, 3'b010, 64'h1002, 64'd1);
    fault(1'b0, 3'b111, 64'h1000, 64'd2);
    fault(1'b0, 3'b011, 64'h1001, 64'd2);
    fault(1'b1, 3'b100, 64'h1000, 64'd2);

    // Reset while waiting on memory
    send(0, 1'b0, 3'b010, 64'h1000, 64'h0);
    chk("t6_issue_ren", ren, 64'd1);
    mready = 1'b1; tick(); mready = 1'b0;
    #1; rst = 1'b1; #1;
    chk("t6_ready", rdy, 64'd0);
    chk("t6_rsp_valid", rv, 64'd0);
    chk("t6_rsp_cause", rc, 64'd0);
    chk("t6_mem", maddr | ren | wen | mwd | mask, 64'd0);
    mvalid = 1'b1; mrdata = 64'h1111_1111; tick(); mvalid = 1'b0;
    rst = 1'b0; #1;
    chk("t6_ready_after", rdy, 64'd1);
    tick(); tick();
    access0(0, 1'b0, 3'b001, 64'h1002, 64'h0, 64'h7FFF_8000, 64'h0000_7FFF,
            64'h1000, 64'hC, 64'h0);

    // XLEN=64 accesses, zero-wait memory
    access0(1, 1'b0, 3'b110, 64'h8000_100C, 64'h0, 64'hDEAD_BEEF_0000_0000,
            64'h0000_0000_DEAD_BEEF, 64'h8000_1008, 64'hF0, 64'h0);
    access0(1, 1'b1, 3'b011, 64'h8000_1008, 64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF,
            64'd0, 64'h8000_1008, 64'hFF, 64'h0123_4567_89AB_CDEF);
    access0(1, 1'b0, 3'b001, 64'h8000_1006, 64'h0, 64'h8001_0000_0000_0000,
            64'hFFFF_FFFF_FFFF_8001, 64'h8000_1000, 64'hC0, 64'h0);
    access0(1, 1'b1, 3'b000, 64'h8000_1005, 64'h77, 64'h0, 64'd0,
            64'h8000_1000, 64'h20, 64'h7777_7777_7777_7777);

    // Timeout with MAX_WAIT=4, then a stray late response in IDLE
    send(2, 1'b0, 3'b010, 64'h3000, 64'h0);
    expect_rsp(64'd0, 64'd3, 5);
    mready = 1'b1; tick(); mready = 1'b0;
    tick(); tick(); tick();
    tick();
    mvalid = 1'b1; mrdata = 64'h1234; tick(); mvalid = 1'b0;
    tick();

    // Completion on the limit cycle wins over timeout
    send(2, 1'b0, 3'b100, 64'h3001, 64'h0);
    expect_rsp(64'h9A, 64'd0, 5);
    mready = 1'b1; tick(); mready = 1'b0;
    tick(); tick();
    mvalid = 1'b1; mrdata = 64'h0000_9A00; tick(); mvalid = 1'b0;
    tick(); tick();

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Parametrised load/store unit between the hart's execute stage and a latency-tolerant data memory. Replaces the single-cycle combinational dmem path with a request/response handshake, supporting variable memory latency, XLEN of 32 or 64, misaligned/illegal-size trapping, and a bus timeout. One access is in flight at a time. Results return to the writeback stage with a cause code.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64. NB = XLEN/8 byte lanes, OB = log2(NB) offset bits.
- MAX_WAIT, 16, cycles allowed in ISSUE+WAIT before timeout; 0 disables timeout.

- i_clk  in  1  clock; all state changes on rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_req_valid  in  1  core presents an access.
- o_req_ready  out  1  unit idle and accepting; 0 while i_rst high.
- i_req_wen  in  1  1 = store, 0 = load.
- i_req_funct3  in  3  RISC-V load/store funct3.
- i_req_addr  in  XLEN  byte address.
- i_req_wdata  in  XLEN  store data, right-justified.
- o_rsp_valid  out  1  one-cycle response pulse.
- o_rsp_rdata  out  XLEN  extended load data; 0 for stores and faults.
- o_rsp_cause  out  2  0 ok, 1 misaligned, 2 illegal size, 3 timeout.
- o_mem_addr  out  XLEN  request address, low OB bits zero.
- o_mem_ren  out  1  read request.
- o_mem_wen  out  1  write request; never high with o_mem_ren.
- o_mem_wdata  out  XLEN  store data, replicated across lanes.
- o_mem_mask  out  NB  active byte lanes.
- i_mem_ready  in  1  memory accepts the request this cycle.
- i_mem_valid  in  1  read data valid / write acknowledged.
- i_mem_rdata  in  XLEN  read word.

## Operation
- States: IDLE, ISSUE, WAIT, RESP. Reset -> IDLE.
- IDLE: o_req_ready=1. On i_req_valid: latch wen, funct3, addr, wdata; decode.
  - Size: funct3[1:0] 00 byte, 01 half, 10 word, 11 double.
  - Illegal (cause 2): funct3 011 or 110 when XLEN=32; 111 always; store with funct3[2]=1. Goes to RESP, no memory access.
  - Misaligned (cause 1): half with addr[0]!=0; word with addr[1:0]!=0; double with addr[2:0]!=0. Goes to RESP, no memory access. Illegal takes priority over misaligned.
  - Otherwise -> ISSUE.
- ISSUE: drive o_mem_addr = addr with low OB bits cleared; assert ren or wen. Mask = ((1<<bytes)-1) << addr[OB-1:0]. Wdata = low (8*bytes) bits replicated NB/bytes times. Hold all outputs stable until i_mem_ready; then -> WAIT.
- WAIT: memory outputs deasserted. On i_mem_valid, capture data and -> RESP. Loads select bytes as i_mem_rdata >> (8*offset), then sign-extend (funct3[2]=0) or zero-extend (funct3[2]=1) from the access size.
- Timeout: counter cleared on entry to ISSUE, increments each cycle in ISSUE/WAIT. When the count equals MAX_WAIT with no completion -> RESP with cause 3 and rdata 0. Completion on the same cycle as the limit wins (cause 0).
- RESP: o_rsp_valid=1 for exactly one cycle, then IDLE. There is no response back-pressure.
- Memory outputs are 0 (addr, wdata, mask included) outside ISSUE.
- i_mem_valid is ignored outside WAIT, so a late response after a timeout is dropped.
- i_mem_ready is ignored outside ISSUE.

## Timing
- Reset (asynchronous): state IDLE, counter 0.
  - All outputs 0: o_req_ready=0, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_cause=0, o_mem_* all 0.
  - o_req_ready rises in the first cycle after i_rst deasserts.
  - Reset mid-access abandons the access immediately; no response is produced.
- Accept at edge N (i_req_valid & o_req_ready).
  - ISSUE occupies cycle N+1.
  - With zero-wait memory (i_mem_ready in N+1, i_mem_valid in N+2), o_rsp_valid is high in cycle N+3. This is the minimum good-path latency: 3 cycles.
  - Fault path: o_rsp_valid in cycle N+1.
  - Timeout path: o_rsp_valid in cycle N+1+MAX_WAIT.
- Next request is accepted at the earliest in the cycle after RESP. Throughput is at most one access per 4 cycles.
- o_rsp_* are registered outputs; o_req_ready and o_mem_* decode from the state register.

## Test plan
- XLEN=32, lb at 0x1003, memory returns 0x80FF_FF12 after 2 wait cycles -> o_mem_addr 0x1000, mask 0b1000, rsp rdata 0xFFFF_FF80, cause 0, rsp at accept+5.
- XLEN=32, sh of 0x0000_ABCD to 0x2002, i_mem_ready held 0 for 3 cycles -> ren/wen/addr/mask/wdata stable throughout; mask 0b1100, wdata 0xABCD_ABCD; single rsp, cause 0.
- XLEN=32, lw at 0x1001 -> cause 1 in accept+1, no o_mem_ren ever. ld (funct3 011) -> cause 2. sbu (store, funct3 100) -> cause 2.
- XLEN=64, lwu at 0x...0C, rdata 0xDEAD_BEEF_0000_0000 -> mask 0xF0, rsp rdata 0x0000_0000_DEAD_BEEF. sd at 0x...08 -> mask 0xFF.
- MAX_WAIT=4, i_mem_ready 1 but i_mem_valid never -> cause 3 at accept+5. A later i_mem_valid pulse in IDLE causes no extra rsp. Next request accepted normally.
- Assert i_rst mid-WAIT -> all outputs 0 asynchronously, no rsp. After release, o_req_ready=1 and an access completes normally.
